// File: rtl/ni_link_buffer_pkg.sv
// Packet-format defines and parity helper shared by the NI link buffer files.
// Optional feature macro used by this block: PARITY_DROP_EN.
`ifndef HDR_SZ
`define HDR_SZ 4
`endif
`ifndef PL_SZ
`define PL_SZ 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif
`ifndef PAR_BIT
`define PAR_BIT (`HDR_SZ+`PL_SZ+`ADDR_SZ-1)
`endif

package ni_link_buffer_pkg;
    localparam int IW = `HDR_SZ + `PL_SZ + `ADDR_SZ;

    function automatic logic parity_ok(input logic [IW-1:0] item);
        return item[`PAR_BIT] == ^item[`PAR_BIT-1:0];
    endfunction
endpackage

// File: rtl/link_fifo_mem.sv
// DEPTH x IW register array for the link buffer: one write port, asynchronous read.
module link_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int IW    = 17
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [IW-1:0]            i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [IW-1:0]            o_rdata
);
    logic [IW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/ni_link_buffer.sv
// Receive buffer between NI transmit port and router input: parity check, FWFT FIFO, skid-based busy.
// Define PARITY_DROP_EN to discard packets that fail parity instead of forwarding them.
module ni_link_buffer
    import ni_link_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IW-1:0]    item_in,
    input  logic             req,
    output logic             channel_busy,
    output logic [IW-1:0]    item_out,
    output logic             valid,
    input  logic             out_busy,
    output logic             parity_err,
    output logic             overflow,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   L_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   L_BUSY = (PTR_W+1)'(DEPTH-1);
    localparam logic [PTR_W:0]   L_ONE  = 1;
    localparam logic [PTR_W-1:0] L_PONE = 1;
    localparam logic [CNT_W-1:0] L_CONE = 1;

    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [PTR_W:0]   r_cnt;
    logic [IW-1:0]    r_head;
    logic             r_valid, r_perr, r_ovf;
    logic [CNT_W-1:0] r_pkt, r_err;

    logic          w_par_ok, w_want, w_full, w_pop, w_push;
    logic          w_load_head, w_mem_empty, w_bypass, w_mem_we, w_mem_rd;
    logic [IW-1:0] w_rdata;

    // r_cnt counts the head register too, so the memory holds r_cnt - r_valid entries.
    always_comb begin
        w_par_ok = parity_ok(item_in);
`ifdef PARITY_DROP_EN
        w_want = req & w_par_ok;
`else
        w_want = req;
`endif
        w_full      = (r_cnt == L_FULL);
        w_pop       = r_valid & ~out_busy;
        w_push      = w_want & (~w_full | w_pop);
        w_load_head = ~r_valid | w_pop;
        w_mem_empty = r_valid ? (r_cnt == L_ONE) : (r_cnt == '0);
        w_bypass    = w_load_head & w_mem_empty & w_push;
        w_mem_we    = w_push & ~w_bypass;
        w_mem_rd    = w_load_head & ~w_mem_empty;
    end

    link_fifo_mem #(.DEPTH(DEPTH), .IW(IW)) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wptr),
        .i_wdata (item_in),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_head  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ovf   <= 1'b0;
            r_pkt   <= '0;
            r_err   <= '0;
        end else begin
            if (w_mem_we) r_wptr <= r_wptr + L_PONE;
            if (w_mem_rd) begin
                r_head  <= w_rdata;
                r_rptr  <= r_rptr + L_PONE;
                r_valid <= 1'b1;
            end else if (w_bypass) begin
                r_head  <= item_in;
                r_valid <= 1'b1;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
            if (w_push && !w_pop)      r_cnt <= r_cnt + L_ONE;
            else if (!w_push && w_pop) r_cnt <= r_cnt - L_ONE;
            if (w_push && r_pkt != '1) r_pkt <= r_pkt + L_CONE;
            if (req && !w_par_ok) begin
                r_perr <= 1'b1;
                if (r_err != '1) r_err <= r_err + L_CONE;
            end
            if (w_want && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    // Busy one slot early: the NI may already be launching a packet when it sees busy.
    assign channel_busy = (r_cnt >= L_BUSY);
    assign item_out     = r_head;
    assign valid        = r_valid;
    assign parity_err   = r_perr;
    assign overflow     = r_ovf;
    assign pkt_count    = r_pkt;
    assign err_count    = r_err;
endmodule
